win_checker: RTL and testbench
==============================

# win_checker

Game-logic block that decides whether the piece just placed on the board completes a line of four. It takes a one-cycle start request carrying the drop coordinates and the player, then reads the board RAM cell by cell along four directions. It produces a one-cycle `win` pulse that drives the score counter's enable, plus a `done` pulse that releases the turn controller.

## Interface

**Parameters**
- `COLS`, 6: board columns, indices 0..COLS-1.
- `ROWS`, 6: board rows; row 0 is the bottom.
- `IDX_W`, 3: width of column and row indices.

**Ports**
- `clock`, in, 1: single clock; all logic is on the rising edge.
- `reset_n`, in, 1: synchronous, active-low reset.
- `start`, in, 1: check request; sampled only in IDLE.
- `drop_col`, in, IDX_W: column of the placed piece.
- `drop_row`, in, IDX_W: row of the placed piece.
- `player`, in, 2: 01 = player 1, 10 = player 2.
- `rd_col`, out, IDX_W: board read column address.
- `rd_row`, out, IDX_W: board read row address.
- `rd_data`, in, 2: cell contents, valid the cycle after the address is driven. Encoding: 00 empty, 01 P1, 10 P2.
- `busy`, out, 1: high from the cycle after start is accepted until done.
- `done`, out, 1: one-cycle pulse when the check completes.
- `win`, out, 1: one-cycle pulse coincident with `done` when a line of ≥4 exists.
- `winner`, out, 2: player of the last completed check; held until the next accepted start.

## Operation

**Start**
- Accepted only in IDLE with `start=1`.
- Latches `drop_col`, `drop_row` and `player`.
- Clears `winner` and enters PROBE.

**Rays**
- Eight rays are checked in fixed order; each direction pair shares one run counter:
  - H+ (+1,0), then H- (-1,0)
  - V+ (0,+1), then V- (0,-1)
  - D+ (+1,+1), then D- (-1,-1)
  - A+ (+1,-1), then A- (-1,+1)
- The run counter resets to 1 at the start of each direction pair. It is 3 bits and saturates at 4.

**States**
- **IDLE**: all outputs 0 except `winner`.
- **PROBE**: compute the next cell on the current ray (step 1..3).
  - If the cell is in bounds, drive `rd_col`/`rd_row` and go to CHECK.
  - If it is out of bounds, or step 3 is done, end the ray and stay in PROBE for the next ray.
  - After A- ends, go to DONE.
- **CHECK**: compare `rd_data` with the latched player.
  - Match: increment the count. If the count is now 4, go to DONE with win set; otherwise return to PROBE with the step advanced.
  - Mismatch (including an empty cell): end the ray and return to PROBE.
- **DONE**: assert `done` for one cycle.
  - If win was set, also assert `win` and set `winner` = player; otherwise `winner` = 00.
  - Return to IDLE.

**Address outputs**
- `rd_col`/`rd_row` hold their last value outside PROBE-with-read cycles.
- Their reset value is 0.

**Edge cases**
- The drop cell itself is never read; it is counted as 1.
- Start with `player` = 00 or 11: go straight to DONE with `win` = 0 and no reads.
- `start` while busy is ignored; no queueing.
- Out-of-range drop coordinates: every probe falls out of bounds along some rays, so the block behaves normally.

## Timing

- Start accepted at edge N: `busy` = 1 from cycle N+1.
- Every in-bounds probe costs 2 cycles (PROBE + CHECK). Every ray termination decided in PROBE costs 1 cycle.
- Worst-case start to `done` is 8 rays × 3 probes × 2 cycles + 8 ray ends + 1 = 57 cycles, always ≤ 57.
- Early exit: `done` is asserted the cycle after the CHECK that reached count 4.
- `done`, `win` and `busy` fall in the same cycle in which the FSM returns to IDLE.
- A new start is accepted in that same IDLE cycle.
- `reset_n` = 0 on any edge, including mid-scan:
  - state goes to IDLE;
  - `busy`, `done`, `win` and `winner` go to 0;
  - `rd_col`/`rd_row` go to 0;
  - no `done` is emitted for the aborted check.

## Structure

- **Shared package `c4_pkg`:**
  - cell encoding constants `CELL_EMPTY`, `CELL_P1`, `CELL_P2`;
  - `COLS`/`ROWS` defaults;
  - the FSM state enum (IDLE, PROBE, CHECK, DONE);
  - the direction delta table (8 signed dx/dy pairs).
- **Sub-module `ray_step`:** combinational. Takes the base coordinates, ray index and step, and returns the next coordinates plus an in-bounds flag. It isolates the signed arithmetic and bounds checks from the FSM.

## Test plan

The bench models the board RAM with 1-cycle read latency.

1. **Horizontal win:** P1 in row 0, cols 0–3; start (col 3, row 0, 01). Required: `win` = 1, `winner` = 01, `done` within 57 cycles, no read of (3,0).
2. **Vertical, no win:** P2 at col 5, rows 0–2; start (5, 2, 10). Required: `done` with `win` = 0 and `winner` = 00.
3. **Anti-diagonal win:** P2 at (0,3), (1,2), (2,1), (3,0); start (0, 3, 10). Required: `win` = 1; no address outside 0..5 is ever driven.
4. **Start while busy:** pulse `start` again during the scan. Required: ignored; exactly one `done`, and the latched coordinates are unchanged.
5. **Reset mid-scan:** `reset_n` = 0 for 1 cycle at scan cycle 10. Required: all outputs 0 the next cycle and no `done`. A subsequent start completes normally.
6. **Invalid player:** start with `player` = 00. Required: `done` 2 cycles after start (cycle N+2), `win` = 0, no reads.

Source files
------------

// File: rtl/c4_pkg.sv
// c4_pkg: shared board encodings, FSM states and ray direction table for the connect-four logic.
package c4_pkg;
  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_P1 = 2'b01;
  localparam logic [1:0] CELL_P2 = 2'b10;
  localparam int C4_COLS = 6;
  localparam int C4_ROWS = 6;
  typedef enum logic [1:0] {IDLE, PROBE, CHECK, DONE} state_t;
  typedef struct packed {
    logic signed [1:0] dx;
    logic signed [1:0] dy;
  } delta_t;
  // Rays come in opposite pairs: H+, H-, V+, V-, D+, D-, A+, A-
  localparam delta_t DIRS [8] = '{
    '{ 2'sd1,  2'sd0}, '{-2'sd1,  2'sd0},
    '{ 2'sd0,  2'sd1}, '{ 2'sd0, -2'sd1},
    '{ 2'sd1,  2'sd1}, '{-2'sd1, -2'sd1},
    '{ 2'sd1, -2'sd1}, '{-2'sd1,  2'sd1}
  };
endpackage

// File: rtl/ray_step.sv
// ray_step: next cell along a ray from the drop position, with a board bounds check.
module ray_step
  import c4_pkg::*;
#(
  parameter int COLS = C4_COLS,
  parameter int ROWS = C4_ROWS,
  parameter int IDX_W = 3
) (
  input  logic [IDX_W-1:0] col,
  input  logic [IDX_W-1:0] row,
  input  logic [2:0]       ray,
  input  logic [2:0]       step,
  output logic [IDX_W-1:0] next_col,
  output logic [IDX_W-1:0] next_row,
  output logic             inb
);
  localparam int W = IDX_W + 3;
  logic signed [W-1:0] c, r, s, nc, nr;
  delta_t d;
  always_comb begin
    d = DIRS[ray];
    c = W'(col);
    r = W'(row);
    s = W'(step);
    nc = d.dx == 2'sd1 ? c + s : d.dx == -2'sd1 ? c - s : c;
    nr = d.dy == 2'sd1 ? r + s : d.dy == -2'sd1 ? r - s : r;
    inb = !nc[W-1] && !nr[W-1] && nc < W'(COLS) && nr < W'(ROWS);
    next_col = nc[IDX_W-1:0];
    next_row = nr[IDX_W-1:0];
  end
endmodule

// File: rtl/win_checker.sv
// win_checker: scans the eight rays around a dropped piece and flags a line of four.
module win_checker
  import c4_pkg::*;
#(
  parameter int COLS = C4_COLS,
  parameter int ROWS = C4_ROWS,
  parameter int IDX_W = 3
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [IDX_W-1:0] drop_col,
  input  logic [IDX_W-1:0] drop_row,
  input  logic [1:0]       player,
  output logic [IDX_W-1:0] rd_col,
  output logic [IDX_W-1:0] rd_row,
  input  logic [1:0]       rd_data,
  output logic             busy,
  output logic             done,
  output logic             win,
  output logic [1:0]       winner
);
  state_t state, state_n, end_state;
  logic [IDX_W-1:0] col_q, row_q, last_col, last_row, next_col, next_row;
  logic [1:0] player_q, winner_q, winner_n;
  logic [2:0] ray, ray_n, step, step_n, count, count_n, end_count;
  logic win_q, win_n, inb, valid, rd_en, match;
  ray_step #(.COLS(COLS), .ROWS(ROWS), .IDX_W(IDX_W)) u_step (
    .col(col_q), .row(row_q), .ray(ray), .step(step),
    .next_col(next_col), .next_row(next_row), .inb(inb)
  );
  assign valid = player_q == CELL_P1 || player_q == CELL_P2;
  assign rd_en = state == PROBE && valid && step != 3'd4 && inb;
  assign match = rd_data == player_q;
  // Address is driven combinationally in PROBE so rd_data is valid in CHECK
  assign rd_col = rd_en ? next_col : last_col;
  assign rd_row = rd_en ? next_row : last_row;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign win = done && win_q;
  assign winner = winner_q;
  assign end_state = ray == 3'd7 ? DONE : PROBE;
  assign end_count = ray[0] ? 3'd1 : count;
  always_comb begin
    state_n = state;
    ray_n = ray;
    step_n = step;
    count_n = count;
    win_n = win_q;
    winner_n = winner_q;
    case (state)
      IDLE: if (start) begin
        state_n = PROBE;
        ray_n = 3'd0;
        step_n = 3'd1;
        count_n = 3'd1;
        win_n = 1'b0;
        winner_n = CELL_EMPTY;
      end
      PROBE: if (!valid) state_n = DONE;
        else if (rd_en) state_n = CHECK;
        else begin
          state_n = end_state;
          ray_n = ray + 3'd1;
          step_n = 3'd1;
          count_n = end_count;
        end
      CHECK: if (match && count == 3'd3) begin
          state_n = DONE;
          count_n = 3'd4;
          win_n = 1'b1;
          winner_n = player_q;
        end else if (match) begin
          state_n = PROBE;
          count_n = count + 3'd1;
          step_n = step + 3'd1;
        end else begin
          state_n = end_state;
          ray_n = ray + 3'd1;
          step_n = 3'd1;
          count_n = end_count;
        end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
      ray <= '0;
      step <= '0;
      count <= '0;
      win_q <= 1'b0;
      winner_q <= CELL_EMPTY;
      col_q <= '0;
      row_q <= '0;
      player_q <= CELL_EMPTY;
      last_col <= '0;
      last_row <= '0;
    end else begin
      state <= state_n;
      ray <= ray_n;
      step <= step_n;
      count <= count_n;
      win_q <= win_n;
      winner_q <= winner_n;
      last_col <= rd_col;
      last_row <= rd_row;
      if (state == IDLE && start) begin
        col_q <= drop_col;
        row_q <= drop_row;
        player_q <= player;
      end
    end
  end
endmodule

// File: tb/tb_win_checker.sv
// tb_win_checker: randomized and directed checks of win_checker against a line-counting board model.
module tb_win_checker;
  localparam int N = 6;
  localparam int DX [8] = '{1, -1, 0, 0, 1, -1, 1, -1};
  localparam int DY [8] = '{0, 0, 1, -1, 1, -1, -1, 1};
  logic clock = 0, reset_n = 0, start = 0;
  logic [2:0] drop_col = 0, drop_row = 0, rd_col, rd_row;
  logic [1:0] player = 0, rd_data = 0, winner;
  logic busy, done, win;
  logic [1:0] board [N][N];
  int n_cmp = 0, n_bad = 0, oob = 0, dread = 0;

  always #5 clock = ~clock;

  win_checker dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .drop_col(drop_col), .drop_row(drop_row), .player(player),
    .rd_col(rd_col), .rd_row(rd_row), .rd_data(rd_data),
    .busy(busy), .done(done), .win(win), .winner(winner)
  );

  always @(posedge clock)
    rd_data <= (rd_col < 3'd6 && rd_row < 3'd6) ? board[rd_col][rd_row] : 2'b00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_board();
    for (int x = 0; x < N; x++)
      for (int y = 0; y < N; y++)
        board[x][y] = 2'b00;
  endtask

  // Walks each ray over the board: a pair wins when 1 + matching cells on both sides reaches 4.
  // Cost: 2 cycles per cell read, 1 cycle to end a ray on bounds or after 3 hits, then 1 DONE cycle.
  function automatic void model(input int c, input int r, input logic [1:0] p, output bit w, output int lat);
    int s = 0;
    int run = 1;
    bit stop;
    w = 0;
    if (p != 2'b01 && p != 2'b10) begin
      lat = 2;
      return;
    end
    for (int d = 0; d < 8; d++) begin
      if (d % 2 == 0) run = 1;
      stop = 0;
      for (int k = 1; k <= 3 && !stop; k++) begin
        int x = c + DX[d] * k;
        int y = r + DY[d] * k;
        if (x < 0 || x >= N || y < 0 || y >= N) begin
          s++;
          stop = 1;
        end else begin
          s += 2;
          if (board[x][y] != p) stop = 1;
          else begin
            run++;
            if (run >= 4) begin
              w = 1;
              lat = s + 1;
              return;
            end
            if (k == 3) s++;
          end
        end
      end
    end
    lat = s + 1;
  endfunction

  task automatic run(input string tag, input int c, input int r, input logic [1:0] p, input bit dup);
    bit ew;
    int el;
    int lat = 0, nd = 0, nw = 0, moved = 0;
    logic [1:0] wn = 0;
    logic [2:0] c0, r0;
    model(c, r, p, ew, el);
    @(negedge clock);
    c0 = rd_col;
    r0 = rd_row;
    dread = 0;
    drop_col = 3'(c);
    drop_row = 3'(r);
    player = p;
    start = 1;
    for (int i = 1; i <= 70; i++) begin
      @(negedge clock);
      start = dup && i == 4;
      if (dup && i == 4) begin
        drop_col = drop_col + 3'd1;
        player = ~p;
      end
      if (i == 1) check({tag, "/busy_rise"}, 32'(busy), 1);
      if (rd_col > 3'd5 || rd_row > 3'd5) oob++;
      if (busy && rd_col == 3'(c) && rd_row == 3'(r)) dread++;
      if (rd_col != c0 || rd_row != r0) moved++;
      if (done) begin
        nd++;
        if (lat == 0) begin
          lat = i;
          wn = winner;
        end
      end
      if (win) nw++;
    end
    start = 0;
    check({tag, "/latency"}, lat, el);
    check({tag, "/done_count"}, nd, 1);
    check({tag, "/win_count"}, nw, 32'(ew));
    check({tag, "/winner"}, 32'(wn), ew ? 32'(p) : 0);
    check({tag, "/winner_held"}, 32'(winner), ew ? 32'(p) : 0);
    check({tag, "/busy_fall"}, 32'(busy), 0);
    if (p == 2'b00 || p == 2'b11) check({tag, "/no_reads"}, moved, 0);
  endtask

  initial begin
    int nd;
    clear_board();
    repeat (2) @(negedge clock);
    check("rst/busy", 32'(busy), 0);
    check("rst/done", 32'(done), 0);
    check("rst/win", 32'(win), 0);
    check("rst/winner", 32'(winner), 0);
    check("rst/rd_col", 32'(rd_col), 0);
    check("rst/rd_row", 32'(rd_row), 0);
    reset_n = 1;

    for (int x = 0; x < 4; x++) board[x][0] = 2'b01;
    run("h_win", 3, 0, 2'b01, 0);
    check("h_win/drop_read", dread, 0);

    clear_board();
    for (int y = 0; y < 3; y++) board[5][y] = 2'b10;
    run("v_nowin", 5, 2, 2'b10, 0);

    clear_board();
    board[0][3] = 2'b10;
    board[1][2] = 2'b10;
    board[2][1] = 2'b10;
    board[3][0] = 2'b10;
    run("a_win", 0, 3, 2'b10, 0);
    check("a_win/oob_addr", oob, 0);
    run("dup_start", 0, 3, 2'b10, 1);

    clear_board();
    @(negedge clock);
    drop_col = 3'd2;
    drop_row = 3'd2;
    player = 2'b01;
    start = 1;
    @(negedge clock);
    start = 0;
    repeat (9) @(negedge clock);
    reset_n = 0;
    @(negedge clock);
    reset_n = 1;
    check("midrst/busy", 32'(busy), 0);
    check("midrst/done", 32'(done), 0);
    check("midrst/win", 32'(win), 0);
    check("midrst/winner", 32'(winner), 0);
    check("midrst/rd_col", 32'(rd_col), 0);
    check("midrst/rd_row", 32'(rd_row), 0);
    nd = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (done) nd++;
    end
    check("midrst/no_done", nd, 0);
    run("post_rst", 2, 2, 2'b01, 0);

    run("bad_pl00", 2, 2, 2'b00, 0);
    run("bad_pl11", 1, 4, 2'b11, 0);

    for (int t = 0; t < 25; t++) begin
      int c, r;
      logic [1:0] p;
      for (int x = 0; x < N; x++)
        for (int y = 0; y < N; y++) begin
          int v = $urandom_range(0, 3);
          board[x][y] = v == 0 ? 2'b00 : v == 3 ? 2'b10 : 2'b01;
        end
      c = $urandom_range(0, 6);
      r = $urandom_range(0, 6);
      p = $urandom_range(0, 9) < 7 ? 2'b01 : $urandom_range(0, 3) == 0 ? 2'b00 : 2'b10;
      run($sformatf("rand%0d", t), c, r, p, 0);
    end
    check("final/oob_addr", oob, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
